// File: rtl/lsb_mem_port_pkg.sv
// Shared definitions for the load/store byte-serial memory port:
// operation encodings, port state enum and the byte-count helper.
package lsb_mem_port_pkg;

    // Operation codes presented by the load/store buffer on lsb_type.
    // Bit 3 selects store, bit 2 selects zero-extension, bits [1:0] the size.
    localparam logic [3:0] LSB_LB  = 4'b0000;
    localparam logic [3:0] LSB_LH  = 4'b0001;
    localparam logic [3:0] LSB_LW  = 4'b0010;
    localparam logic [3:0] LSB_LBU = 4'b0100;
    localparam logic [3:0] LSB_LHU = 4'b0101;
    localparam logic [3:0] LSB_SB  = 4'b1000;
    localparam logic [3:0] LSB_SH  = 4'b1001;
    localparam logic [3:0] LSB_SW  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STORE  = 2'd2,
        ST_IOWAIT = 2'd3
    } lsb_state_e;

    // Number of bytes moved for a size field; the unused 2'b11 size is
    // treated as a full word so the port never hangs on a bad code.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsb_mem_port_ext.sv
// Load result formatter: sign/zero extension of the raw little-endian
// bytes gathered by the port. Store codes always report zero.
module lsb_load_ext
    import lsb_mem_port_pkg::*;
(
    input  logic [3:0]  lsb_type,
    input  logic [31:0] raw,
    output logic [31:0] load_val
);

    // Select the extension from the full operation code.
    always_comb begin
        load_val = raw;
        case (lsb_type)
            LSB_LB:  load_val = {{24{raw[7]}}, raw[7:0]};
            LSB_LH:  load_val = {{16{raw[15]}}, raw[15:0]};
            LSB_LW:  load_val = raw;
            LSB_LBU: load_val = {24'd0, raw[7:0]};
            LSB_LHU: load_val = {16'd0, raw[15:0]};
            LSB_SB, LSB_SH, LSB_SW: load_val = 32'd0;
            default: load_val = lsb_type[3] ? 32'd0 : raw;
        endcase
    end

endmodule

// File: rtl/lsb_mem_port.sv
// Byte-serial memory port between the load/store buffer and an 8-bit
// synchronous RAM. Loads issue one address per cycle and gather bytes one
// cycle later; stores write one byte per cycle. The port returns to IDLE in
// the completion cycle so back-to-back requests see no bubble.
// Optional build macro LSMEM_IO_STALL_EN: stores to addr[17:16]==2'b11 wait
// in IOWAIT while io_buffer_full is high before writing.
module lsb_mem_port
    import lsb_mem_port_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        ls_enable,
    input  logic [31:0] addr,
    input  logic [31:0] store_val,
    input  logic [3:0]  lsb_type,
    output logic        ls_finished,
    output logic [31:0] load_val,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        port_busy
);

    lsb_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  type_q, type_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] raw_q, raw_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        kill_q, kill_d;
    logic        ls_finished_q, ls_finished_d;
    logic [31:0] load_val_q, load_val_d;

    logic [2:0]  n_bytes;
    logic [31:0] ext_val;

`ifdef LSMEM_IO_STALL_EN
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
`endif

    // Byte k of the latched store word.
    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = d[15:8];
            3'd2:    b = d[23:16];
            3'd3:    b = d[31:24];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

    // Insert the byte returned for issue slot (cnt-1) into the raw word.
    function automatic logic [31:0] merge_byte(input logic [31:0] r, input logic [7:0] b,
                                               input logic [2:0] cnt);
        logic [31:0] m;
        case (cnt)
            3'd1:    m = {r[31:8], b};
            3'd2:    m = {r[31:16], b, r[7:0]};
            3'd3:    m = {r[31:24], b, r[15:0]};
            3'd4:    m = {b, r[23:0]};
            default: m = r;
        endcase
        return m;
    endfunction

    assign n_bytes = byte_count(type_q[1:0]);

    lsb_load_ext u_ext (
        .lsb_type (type_q),
        .raw      (raw_d),
        .load_val (ext_val)
    );

    // Next-state and datapath update; everything holds while rdy_in is low.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        type_d        = type_q;
        sdata_d       = sdata_q;
        raw_d         = raw_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        kill_d        = kill_q;
        ls_finished_d = ls_finished_q;
        load_val_d    = load_val_q;

        if (rdy_in) begin
            ls_finished_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ls_enable && !clear) begin
                        type_d     = lsb_type;
                        sdata_d    = store_val;
                        raw_d      = 32'd0;
                        mem_a_d    = addr;
                        mem_dout_d = store_val[7:0];
                        cnt_d      = 3'd0;
                        kill_d     = 1'b0;
                        if (lsb_type[3]) begin
`ifdef LSMEM_IO_STALL_EN
                            state_d = (addr[17:16] == 2'b11) ? ST_IOWAIT : ST_STORE;
`else
                            state_d = ST_STORE;
`endif
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (clear) begin
                        // Flushed loads abandon outstanding bytes immediately.
                        state_d = ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            raw_d = merge_byte(raw_q, mem_din, cnt_q);
                        end
                        if (cnt_q == n_bytes) begin
                            state_d       = ST_IDLE;
                            ls_finished_d = 1'b1;
                            load_val_d    = ext_val;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) < n_bytes) begin
                                mem_a_d = mem_a_q + 32'd1;
                            end
                        end
                    end
                end

                ST_STORE: begin
                    // A flushed store still writes every byte, it just stays silent.
                    if (clear) begin
                        kill_d = 1'b1;
                    end
                    if (cnt_q == (n_bytes - 3'd1)) begin
                        state_d = ST_IDLE;
                        if (!(kill_q || clear)) begin
                            ls_finished_d = 1'b1;
                            load_val_d    = ext_val;
                        end
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = pick_byte(sdata_q, cnt_q + 3'd1);
                    end
                end

                ST_IOWAIT: begin
                    if (clear) begin
                        kill_d = 1'b1;
                    end
`ifdef LSMEM_IO_STALL_EN
                    if (!io_buffer_full) begin
                        state_d = ST_STORE;
                    end
`else
                    state_d = ST_STORE;
`endif
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            type_q        <= 4'd0;
            sdata_q       <= 32'd0;
            raw_q         <= 32'd0;
            mem_a_q       <= 32'd0;
            mem_dout_q    <= 8'd0;
            kill_q        <= 1'b0;
            ls_finished_q <= 1'b0;
            load_val_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            type_q        <= type_d;
            sdata_q       <= sdata_d;
            raw_q         <= raw_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            kill_q        <= kill_d;
            ls_finished_q <= ls_finished_d;
            load_val_q    <= load_val_d;
        end
    end

    assign ls_finished = ls_finished_q;
    assign load_val    = load_val_q;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = rdy_in && (state_q == ST_STORE);
    assign port_busy   = (state_q != ST_IDLE);

endmodule

// File: doc/lsb_mem_port.md
LSB_MEM_PORT -- requirements
Module: lsb_mem_port

Interface
REQ-001 clk_in  input  1  system clock; single clock domain.
REQ-002 rst_in  input  1  reset, asynchronous, active-high.
REQ-003 rdy_in  input  1  global enable; when low all state holds.
REQ-004 clear  input  1  pipeline flush, acts only when rdy_in high.
REQ-005 ls_enable  input  1  LSB request valid.
REQ-006 addr  input  32  byte address of request.
REQ-007 store_val  input  32  store data, little-endian.
REQ-008 lsb_type  input  4  op: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010.
REQ-009 ls_finished  output  1  one-cycle completion pulse to LSB.
REQ-010 load_val  output  32  extended load result, valid with ls_finished.
REQ-011 mem_din  input  8  RAM read byte, valid one cycle after mem_a.
REQ-012 mem_dout  output  8  RAM write byte.
REQ-013 mem_a  output  32  RAM byte address.
REQ-014 mem_wr  output  1  RAM write strobe.
REQ-015 io_buffer_full  input  1  UART buffer full, used only with LSMEM_IO_STALL_EN.
REQ-016 port_busy  output  1  high whenever state is not IDLE; tells fetch arbiter the RAM bus is owned.

Function
REQ-017 States SHALL be IDLE, LOAD, STORE, IOWAIT; byte count N = 1 << lsb_type[1:0], encoding 11 treated as N=4.
REQ-018 In IDLE with ls_enable && !clear at an edge, the block SHALL latch addr, type, store_val and enter LOAD (type[3]=0) or STORE (type[3]=1).
REQ-019 LOAD SHALL drive mem_a = addr+k, mem_wr=0, for k=0..N-1 on consecutive cycles after acceptance, capturing byte k from mem_din one cycle later into bits [8k+7:8k].
REQ-020 ls_finished SHALL pulse N+1 cycles after acceptance edge for loads, N cycles for stores, and return to 0 the next cycle.
REQ-021 load_val SHALL be sign-extended from bit 7 (LB) / bit 15 (LH), zero-extended for LBU/LHU, unmodified for LW; stores report load_val=0.
REQ-022 STORE SHALL drive mem_wr=1, mem_a=addr+k, mem_dout=store_val[8k+7:8k] for k=0..N-1 on consecutive cycles, then mem_wr=0.
REQ-023 Address increment SHALL be 32-bit modulo (0xFFFFFFFF+1 = 0).
REQ-024 State SHALL be IDLE during the ls_finished cycle so a new request is accepted that same edge (back-to-back, no bubble).
REQ-025 clear during LOAD SHALL return to IDLE next edge, mem_wr=0, no ls_finished pulse.
REQ-026 clear during STORE/IOWAIT SHALL let remaining bytes complete but suppress ls_finished.
REQ-027 No request SHALL be accepted in a cycle where clear is high.
REQ-028 rdy_in low SHALL freeze state, counters, mem_a, mem_dout; mem_wr output SHALL be gated to 0.

Reset
REQ-029 On rst_in: state IDLE, ls_finished=0, load_val=0, mem_a=0, mem_dout=0, mem_wr=0, port_busy=0, byte counter 0, latched fields 0.

Configuration
REQ-030 Macro LSMEM_IO_STALL_EN defined: a store with addr[17:16]==2'b11 SHALL enter IOWAIT and hold mem_wr=0 while io_buffer_full is high, entering STORE the cycle after it is low; undefined: io_buffer_full ignored, IOWAIT unreachable.

Structure
REQ-031 Shared package SHALL hold the lsb_type encodings, state enum, and byte-count helper constant.
REQ-032 Sign/zero extension SHALL be one combinational sub-module lsb_load_ext (type, raw 32 bits -> load_val).

Verification
REQ-033 LB addr=0x100, RAM[0x100]=0x80 -> mem_a=0x100 one cycle, ls_finished 2 cycles after accept, load_val=0xFFFFFF80.
REQ-034 LW addr=0x200, bytes 11,22,33,44 -> ls_finished 5 cycles after accept, load_val=0x44332211; then LHU same addr issued in finish cycle -> accepted same edge, load_val=0x00002211.
REQ-035 SH addr=0x300, store_val=0xDEADBEEF -> mem_wr cycles write 0xEF@0x300, 0xBE@0x301, ls_finished 2 cycles after accept, RAM[0x302] unchanged.
REQ-036 LW accepted, clear on cycle 2 -> IDLE next edge, no ls_finished, port_busy=0.
REQ-037 With LSMEM_IO_STALL_EN: SB addr=0x30000 with io_buffer_full high 3 cycles -> mem_wr low those cycles, one write of byte after release, then ls_finished.
REQ-038 rst_in asserted mid-SW -> all outputs 0 immediately, no further writes.
